// File: rtl/bsg_link_isdr_rx_ctrl.sv
// ---------------------------------------------------------------------------
// bsg_link_isdr_rx_ctrl
//
// Receive-side controller for the ISDR link PHY. Words arrive already
// registered by the PHY. The controller holds off until the link is enabled
// and the line has stayed quiet for quiet_cycles_p consecutive cycles. It then
// buffers incoming words in a FIFO for the core and returns credits to the
// remote sender as a toggling token line.
//
// Optional feature macro: BSG_LINK_ISDR_RX_CTRL_STATS_EN
//   When defined, port rx_count_o is added. It is a saturating 32-bit count
//   of accepted pushes that is cleared only by reset.
//
// Ports
//   clk_i         in   1        PHY forwarded clock; the only clock
//   reset_n_i     in   1        synchronous reset, active-low
//   link_enable_i in   1        software link enable
//   phy_data_i    in   width_p  registered word from the PHY
//   phy_v_i       in   1        registered valid bit from the PHY
//   core_data_o   out  width_p  FIFO head word (meaningful only when core_v_o=1)
//   core_v_o      out  1        FIFO non-empty
//   core_yumi_i   in   1        core consumes the head word this cycle
//   token_o       out  1        credit token; toggles once per decimated batch
//   link_ready_o  out  1        high while in ACTIVE
//   overflow_o    out  1        sticky: a word arrived while the FIFO was full
//   rx_count_o    out  32       (stats build only) accepted push count
//
// Handshake: core_v_o/core_yumi_i follow valid/yumi semantics. A word is
// transferred at a rising edge where core_v_o=1 and core_yumi_i=1. core_v_o
// never depends combinationally on core_yumi_i. A yumi asserted while
// core_v_o=0 is ignored. The PHY side has no backpressure: a word offered
// with phy_v_i=1 is either accepted or dropped (silently outside ACTIVE,
// with the sticky overflow flag when the FIFO is full).
// ---------------------------------------------------------------------------
module bsg_link_isdr_rx_ctrl #(
  parameter int width_p               = 8,
  parameter int fifo_els_p            = 16,
  parameter int lg_token_decimation_p = 2,
  parameter int quiet_cycles_p        = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               link_enable_i,
  input  logic [width_p-1:0] phy_data_i,
  input  logic               phy_v_i,
  output logic [width_p-1:0] core_data_o,
  output logic               core_v_o,
  input  logic               core_yumi_i,
  output logic               token_o,
  output logic               link_ready_o,
  output logic               overflow_o
`ifdef BSG_LINK_ISDR_RX_CTRL_STATS_EN
  ,
  output logic [31:0]        rx_count_o
`endif
);

  // -------------------------------------------------------------------------
  // Derived widths and constants
  // -------------------------------------------------------------------------
  localparam int ptr_w_lp   = $clog2(fifo_els_p);
  localparam int occ_w_lp   = $clog2(fifo_els_p) + 1;
  localparam int quiet_w_lp = (quiet_cycles_p > 1) ? $clog2(quiet_cycles_p) : 1;
  // A decimation of 2**0 would give a zero-width counter. Keep one bit and
  // treat every pop as a wrap in that case.
  localparam int tok_w_lp   = (lg_token_decimation_p > 0) ? lg_token_decimation_p : 1;

  localparam logic [occ_w_lp-1:0]   occ_full_lp   = occ_w_lp'(fifo_els_p);
  localparam logic [quiet_w_lp-1:0] quiet_last_lp = quiet_w_lp'(quiet_cycles_p - 1);
  localparam logic [tok_w_lp-1:0]   tok_last_lp   = {tok_w_lp{1'b1}};

  // -------------------------------------------------------------------------
  // State. The FSM state is a named register so checkers can bind to it.
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_QUIET  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  state_e                state;
  logic [quiet_w_lp-1:0] quiet_cnt;
  logic [ptr_w_lp-1:0]   wptr;
  logic [ptr_w_lp-1:0]   rptr;
  logic [occ_w_lp-1:0]   occ;
  logic [tok_w_lp-1:0]   tok_cnt;
  logic [width_p-1:0]    mem [fifo_els_p];

  // -------------------------------------------------------------------------
  // Datapath controls. These are all decoded from the occupancy at the start
  // of the cycle, so a same-cycle pop never makes room for a push.
  // -------------------------------------------------------------------------
  logic full;
  logic active;
  logic flush;
  logic push;
  logic drop;
  logic pop;
  logic tok_wrap;

  assign full   = (occ == occ_full_lp);
  assign active = (state == ST_ACTIVE);
  // Leaving QUIET/ACTIVE because the enable dropped empties the FIFO and
  // restarts credit accounting. The sender is re-synchronised by the new
  // quiet window.
  assign flush  = (state != ST_IDLE) && !link_enable_i;
  assign push   = active && link_enable_i && phy_v_i && !full;
  assign drop   = active && phy_v_i && full;
  assign pop    = core_yumi_i && core_v_o;

  assign tok_wrap = (lg_token_decimation_p == 0) ? 1'b1 : (tok_cnt == tok_last_lp);

  assign core_v_o    = (occ != '0);
  assign core_data_o = mem[rptr];

  // -------------------------------------------------------------------------
  // Control: FSM, FIFO pointers/occupancy, token and overflow
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state        <= ST_IDLE;
      quiet_cnt    <= '0;
      link_ready_o <= 1'b0;
      wptr         <= '0;
      rptr         <= '0;
      occ          <= '0;
      tok_cnt      <= '0;
      token_o      <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (link_enable_i) begin
            state     <= ST_QUIET;
            quiet_cnt <= '0;
          end
        end
        ST_QUIET: begin
          if (!link_enable_i) begin
            state <= ST_IDLE;
          end else if (phy_v_i) begin
            // Any activity restarts the quiet window.
            quiet_cnt <= '0;
          end else if (quiet_cnt == quiet_last_lp) begin
            state        <= ST_ACTIVE;
            link_ready_o <= 1'b1;
          end else begin
            quiet_cnt <= quiet_cnt + 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!link_enable_i) begin
            state        <= ST_IDLE;
            link_ready_o <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          link_ready_o <= 1'b0;
        end
      endcase

      if (flush) begin
        wptr    <= '0;
        rptr    <= '0;
        occ     <= '0;
        tok_cnt <= '0;
        token_o <= 1'b0;
      end else begin
        if (push) begin
          wptr <= wptr + 1'b1;
        end
        if (pop) begin
          rptr    <= rptr + 1'b1;
          tok_cnt <= tok_cnt + 1'b1;
          if (tok_wrap) begin
            token_o <= ~token_o;
          end
        end
        if (push && !pop) begin
          occ <= occ + 1'b1;
        end else if (!push && pop) begin
          occ <= occ - 1'b1;
        end
      end

      // Sticky until reset; a flush does not clear it.
      if (drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage. The contents are don't-care until written, so there is no
  // reset. Pointers wrap naturally because the depth is a power of two.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr] <= phy_data_i;
    end
  end

`ifdef BSG_LINK_ISDR_RX_CTRL_STATS_EN
  // -------------------------------------------------------------------------
  // Accepted-push statistics, saturating.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rx_count_o <= '0;
    end else if (push && (rx_count_o != 32'hFFFF_FFFF)) begin
      rx_count_o <= rx_count_o + 32'd1;
    end
  end
`endif

endmodule
